// File: rtl/wb_regfile_206.sv
// ----------------------------------------------------------------------------
// wb_regfile_206
//   Write-back stage plus architectural register file of the 5-stage pipeline.
//   Picks the write-back value from the MEM/WB register outputs, commits it to
//   a REG_NUM x DATA_W register file, serves the two ID-stage read ports (with
//   same-cycle write-to-read bypass) and counts retired register writes.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   ALU_ans_Wr       ALU result from MEM/WB
//   Mem_Data_Wr      load data from MEM/WB
//   PC_Addr_Wr       address of the instruction in WB
//   Reg_Target_Wr    destination register index
//   MemToReg_Wr      select load data
//   RegWr_Wr         register write enable
//   Rtype_L_Wr       jalr: write link value to Reg_Target_Wr
//   Jal_Wr           jal: write link value to LINK_REG
//   Ra_Addr, Rb_Addr read port indices
//   busA, busB       read data
//   Wb_Data, Wb_Reg, Wb_En  effective write (combinational, for forwarding)
//   Retire_Cnt       count of committed register writes (wraps)
// ----------------------------------------------------------------------------
module wb_regfile_206 #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_NUM     = 32,
    parameter int unsigned LINK_REG    = 31,
    parameter int unsigned LINK_OFFSET = 4,
    localparam int unsigned IdxW       = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ALU_ans_Wr,
    input  logic [DATA_W-1:0] Mem_Data_Wr,
    input  logic [DATA_W-1:0] PC_Addr_Wr,
    input  logic [IdxW-1:0]   Reg_Target_Wr,
    input  logic              MemToReg_Wr,
    input  logic              RegWr_Wr,
    input  logic              Rtype_L_Wr,
    input  logic              Jal_Wr,
    input  logic [IdxW-1:0]   Ra_Addr,
    input  logic [IdxW-1:0]   Rb_Addr,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    output logic [DATA_W-1:0] Wb_Data,
    output logic [IdxW-1:0]   Wb_Reg,
    output logic              Wb_En,
    output logic [31:0]       Retire_Cnt
);

    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [DATA_W-1:0] link_val;
    logic [31:0]       retire_cnt_q;
    logic [31:0]       retire_cnt_d;
    logic              bypass_en;

    assign link_val = PC_Addr_Wr + DATA_W'(LINK_OFFSET);

    // Fixed priority: Jal > Rtype_L > MemToReg > ALU.
    always_comb begin
        Wb_Data = ALU_ans_Wr;
        if (Jal_Wr || Rtype_L_Wr) begin
            Wb_Data = link_val;
        end else if (MemToReg_Wr) begin
            Wb_Data = Mem_Data_Wr;
        end
    end

    always_comb begin
        Wb_Reg = Jal_Wr ? IdxW'(LINK_REG) : Reg_Target_Wr;
        Wb_En  = (RegWr_Wr | Jal_Wr) & (Wb_Reg != '0);
    end

    // Bypass only outside reset so that X on the controls cannot leak onto the buses.
    assign bypass_en = rst_n & Wb_En;

    always_comb begin
        busA = '0;
        busB = '0;
        if (rst_n) begin
            if (Ra_Addr == '0) begin
                busA = '0;
            end else if (bypass_en && (Ra_Addr == Wb_Reg)) begin
                busA = Wb_Data;
            end else begin
                busA = regs_q[Ra_Addr];
            end
            if (Rb_Addr == '0) begin
                busB = '0;
            end else if (bypass_en && (Rb_Addr == Wb_Reg)) begin
                busB = Wb_Data;
            end else begin
                busB = regs_q[Rb_Addr];
            end
        end
    end

    // Wb_En already excludes index 0, so entry 0 stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs_q[i] <= '0;
            end
        end else if (Wb_En) begin
            regs_q[Wb_Reg] <= Wb_Data;
        end
    end

    assign retire_cnt_d = retire_cnt_q + {31'b0, Wb_En};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign Retire_Cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile_206.sv
module tb_wb_regfile_206;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ALU_ans_Wr, Mem_Data_Wr, PC_Addr_Wr;
    logic [4:0]  Reg_Target_Wr, Ra_Addr, Rb_Addr;
    logic        MemToReg_Wr, RegWr_Wr, Rtype_L_Wr, Jal_Wr;
    logic [31:0] busA, busB, Wb_Data, Retire_Cnt;
    logic [4:0]  Wb_Reg;
    logic        Wb_En;

    wb_regfile_206 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ALU_ans_Wr    (ALU_ans_Wr),
        .Mem_Data_Wr   (Mem_Data_Wr),
        .PC_Addr_Wr    (PC_Addr_Wr),
        .Reg_Target_Wr (Reg_Target_Wr),
        .MemToReg_Wr   (MemToReg_Wr),
        .RegWr_Wr      (RegWr_Wr),
        .Rtype_L_Wr    (Rtype_L_Wr),
        .Jal_Wr        (Jal_Wr),
        .Ra_Addr       (Ra_Addr),
        .Rb_Addr       (Rb_Addr),
        .busA          (busA),
        .busB          (busB),
        .Wb_Data       (Wb_Data),
        .Wb_Reg        (Wb_Reg),
        .Wb_En         (Wb_En),
        .Retire_Cnt    (Retire_Cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] v);
        push(tag, v);
        pop_check(obs);
    endtask

    task automatic drive(input logic regwr, input logic jal, input logic rtl, input logic m2r,
                         input logic [4:0] tgt, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc);
        RegWr_Wr      = regwr;
        Jal_Wr        = jal;
        Rtype_L_Wr    = rtl;
        MemToReg_Wr   = m2r;
        Reg_Target_Wr = tgt;
        ALU_ans_Wr    = alu;
        Mem_Data_Wr   = mem;
        PC_Addr_Wr    = pc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    // Commit edge, then settle 2 time units past it with the write controls idle.
    task automatic step();
        @(posedge clk);
        #2;
        idle();
        #1;
    endtask

    task automatic read(input logic [4:0] a, input logic [4:0] b);
        Ra_Addr = a;
        Rb_Addr = b;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        read(5'd0, 5'd0);
        #12;
        read(5'd1, 5'd31);
        chk("rst_busA", busA, 32'h0);
        chk("rst_busB", busB, 32'h0);
        chk("rst_cnt", Retire_Cnt, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;

        // reg5 = 0x1234
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0, 32'h0);
        exp_cnt++;
        push("pre_reg5", 32'h1234);
        push("pre_cnt", exp_cnt);
        step();
        read(5'd5, 5'd0);
        pop_check(busA);
        pop_check(Retire_Cnt);

        // 1: async reset mid-cycle with a write pending
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 32'hAAAA, 32'h0, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_busA", busA, 32'h0);
        chk("rst_async_cnt", Retire_Cnt, 32'h0);
        RegWr_Wr = 1'bx;
        Jal_Wr = 1'bx;
        Reg_Target_Wr = 5'bx;
        @(posedge clk);
        #3;
        idle();
        rst_n = 1'b1;
        exp_cnt = 0;
        read(5'd5, 5'd6);
        chk("rst_reg5", busA, 32'h0);
        chk("rst_reg6_no_commit", busB, 32'h0);
        chk("rst_cnt_after", Retire_Cnt, 32'h0);

        // 2: bypass on both ports, then storage
        read(5'd7, 5'd7);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'hDEADBEEF, 32'h0, 32'h0);
        #1;
        chk("byp_busA", busA, 32'hDEADBEEF);
        chk("byp_busB", busB, 32'hDEADBEEF);
        chk("byp_en", {31'b0, Wb_En}, 32'h1);
        exp_cnt++;
        push("st_reg7", 32'hDEADBEEF);
        push("st_cnt", exp_cnt);
        step();
        pop_check(busA);
        pop_check(Retire_Cnt);

        // reg3 = 0x33; bypass on port A only, port B from storage
        read(5'd3, 5'd7);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h33, 32'h0, 32'h0);
        #1;
        chk("byp_a_only", busA, 32'h33);
        chk("nobyp_b", busB, 32'hDEADBEEF);
        exp_cnt++;
        step();

        // 3: Jal overrides MemToReg and target, writes with RegWr=0
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h1111, 32'h5555, 32'h00400010);
        #1;
        chk("jal_data", Wb_Data, 32'h00400014);
        chk("jal_reg", {27'b0, Wb_Reg}, 32'd31);
        chk("jal_en", {31'b0, Wb_En}, 32'h1);
        exp_cnt++;
        push("jal_reg31", 32'h00400014);
        push("jal_reg3_kept", 32'h33);
        push("jal_cnt", exp_cnt);
        step();
        read(5'd31, 5'd3);
        pop_check(busA);
        pop_check(busB);
        pop_check(Retire_Cnt);

        // 4: jalr link wraps; beats MemToReg
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h99, 32'h0, 32'h0);
        exp_cnt++;
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h1111, 32'h5555, 32'hFFFFFFFC);
        #1;
        chk("jalr_en", {31'b0, Wb_En}, 32'h1);
        chk("jalr_data", Wb_Data, 32'h0);
        exp_cnt++;
        push("jalr_reg9", 32'h0);
        step();
        read(5'd9, 5'd0);
        pop_check(busA);

        // MemToReg selects load data over ALU result
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 32'h1111, 32'hCAFEF00D, 32'h0);
        exp_cnt++;
        push("m2r_reg10", 32'hCAFEF00D);
        step();
        read(5'd10, 5'd0);
        pop_check(busA);

        // 5: write to r0 is dropped
        read(5'd0, 5'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h5, 32'h0, 32'h0);
        #1;
        chk("r0_en", {31'b0, Wb_En}, 32'h0);
        chk("r0_byp", busA, 32'h0);
        push("r0_busA", 32'h0);
        push("r0_cnt", exp_cnt);
        step();
        pop_check(busA);
        pop_check(Retire_Cnt);

        // 6: counter wrap via preloaded next-state
        force dut.retire_cnt_d = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        release dut.retire_cnt_d;
        #2;
        chk("cnt_preload", Retire_Cnt, 32'hFFFFFFFF);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 32'h12, 32'h0, 32'h0);
        push("cnt_wrap", 32'h0);
        push("wrap_reg12", 32'h12);
        step();
        pop_check(Retire_Cnt);
        read(5'd12, 5'd0);
        pop_check(busA);

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
